// File: rtl/uart_wb_master_pkg.sv
// Shared definitions for the UART-driven Wishbone initiator: command codes,
// status bytes and the bridge FSM encoding.
package uart_wb_master_pkg;
    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_RD  = 2'b10;
    localparam logic [1:0] CMD_RSV = 2'b11;

    localparam logic [7:0] ST_OK  = 8'hA5;
    localparam logic [7:0] ST_TMO = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_BUS,
        S_RESP_DATA,
        S_RESP_STAT
    } state_t;
endpackage

// File: rtl/uart_rx.sv
// UART receiver core: 8N1, bit period of div+1 clocks, majority-free glitch
// filter that needs GLITCH_FILTER equal samples before the line level changes.
module uart_rx #(
    parameter int DIV_WIDTH     = 8,
    parameter int GLITCH_FILTER = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 rx,
    output logic [7:0]           data,
    output logic                 strobe
);
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t              state;
    logic [1:0]             sync;
    logic [GLITCH_FILTER-1:0] hist;
    logic                   rx_f;
    logic [DIV_WIDTH-1:0]   cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= 2'b11;
            hist    <= '1;
            rx_f    <= 1'b1;
            state   <= R_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            data    <= '0;
            strobe  <= 1'b0;
        end else begin
            sync   <= {sync[0], rx};
            hist   <= GLITCH_FILTER'({hist, sync[1]});
            if (&hist)       rx_f <= 1'b1;
            else if (~|hist) rx_f <= 1'b0;
            strobe <= 1'b0;
            case (state)
                R_IDLE: if (!rx_f) begin
                    cnt   <= div >> 1;
                    state <= R_START;
                end
                // Re-check the start bit at mid-bit to reject short glitches
                R_START: if (cnt == '0) begin
                    cnt     <= div;
                    bit_idx <= '0;
                    state   <= rx_f ? R_IDLE : R_DATA;
                end else cnt <= cnt - 1'b1;
                R_DATA: if (cnt == '0) begin
                    sh  <= {rx_f, sh[7:1]};
                    cnt <= div;
                    if (bit_idx == 3'd7) state <= R_STOP;
                    bit_idx <= bit_idx + 1'b1;
                end else cnt <= cnt - 1'b1;
                R_STOP: if (cnt == '0) begin
                    if (rx_f) begin
                        data   <= sh;
                        strobe <= 1'b1;
                    end
                    state <= R_IDLE;
                end else cnt <= cnt - 1'b1;
                default: state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter core: 8N1, bit period of div+1 clocks. ack is high in the
// cycle a byte is accepted; data/valid must be held until then.
module uart_tx #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 valid,
    input  logic [7:0]           data,
    output logic                 ack,
    output logic                 tx
);
    logic                 busy;
    logic [9:0]           sh;
    logic [DIV_WIDTH-1:0] cnt;
    logic [3:0]           nbits;

    assign ack = valid && !busy;
    assign tx  = sh[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            sh    <= '1;
            cnt   <= '0;
            nbits <= '0;
        end else if (!busy) begin
            if (valid) begin
                sh    <= {1'b1, data, 1'b0};
                cnt   <= div;
                nbits <= 4'd9;
                busy  <= 1'b1;
            end
        end else if (cnt == '0) begin
            // Shifting in ones leaves the line idling high after the stop bit
            if (nbits == '0) busy <= 1'b0;
            else begin
                sh    <= {1'b1, sh[9:1]};
                nbits <= nbits - 1'b1;
                cnt   <= div;
            end
        end else cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/uart_wb_master.sv
// Host debug bridge: framed UART commands become single Wishbone read/write
// cycles; status and read data are returned over the same UART.
module uart_wb_master
    import uart_wb_master_pkg::*;
#(
    parameter int               DIV_WIDTH  = 8,
    parameter logic [DIV_WIDTH-1:0] DIV    = 8'd24,
    parameter int               AW         = 16,
    parameter int               DW         = 16,
    parameter int               TO_WIDTH   = 8,
    parameter int               IDLE_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rx,
    output logic          uart_tx,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_wdata,
    input  logic [DW-1:0] wb_rdata,
    output logic          wb_we,
    output logic          wb_cyc,
    input  logic          wb_ack
);
    localparam int AB = AW / 8;
    localparam int DB = DW / 8;
    localparam int CW = 8;
    localparam logic [TO_WIDTH-1:0] TO_LAST = {{(TO_WIDTH-1){1'b1}}, 1'b0};

    state_t                state;
    logic                  is_wr;
    logic [CW-1:0]         byte_cnt;
    logic [CW-1:0]         last_cnt;
    logic [TO_WIDTH-1:0]   to_cnt;
    logic [IDLE_WIDTH-1:0] idle_cnt;
    logic [7:0]            status;
    logic [DW-1:0]         rd_buf;
    logic [DW-1:0]         rd_next;
    logic [7:0]            rx_data;
    logic                  rx_stb;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ack;
    logic                  cmd_valid;
    logic                  bus_done;
    logic [DW-1:0]         bus_data;
    logic [7:0]            bus_stat;

    uart_rx #(.DIV_WIDTH(DIV_WIDTH), .GLITCH_FILTER(2)) u_rx (
        .clk(clk), .rst(rst), .div(DIV), .rx(uart_rx),
        .data(rx_data), .strobe(rx_stb)
    );

    uart_tx #(.DIV_WIDTH(DIV_WIDTH)) u_tx (
        .clk(clk), .rst(rst), .div(DIV), .valid(tx_valid),
        .data(tx_data), .ack(tx_ack), .tx(uart_tx)
    );

    assign cmd_valid = (rx_data[7:6] != CMD_NOP) && (rx_data[7:6] != CMD_RSV);
    assign last_cnt  = (state == S_ADDR) ? CW'(AB - 1) : CW'(DB - 1);
    // Ack is checked ahead of the terminal count so a last-cycle ack still wins
    assign bus_done  = wb_ack || (to_cnt == TO_LAST);
    assign bus_data  = wb_ack ? wb_rdata : '0;
    assign bus_stat  = wb_ack ? ST_OK : ST_TMO;
    assign rd_next   = DW'({rd_buf, 8'h00});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            is_wr    <= 1'b0;
            byte_cnt <= '0;
            to_cnt   <= '0;
            idle_cnt <= '0;
            status   <= '0;
            rd_buf   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            wb_addr  <= '0;
            wb_wdata <= '0;
            wb_we    <= 1'b0;
            wb_cyc   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (rx_stb && cmd_valid) begin
                    is_wr    <= (rx_data[7:6] == CMD_WR);
                    byte_cnt <= '0;
                    idle_cnt <= '0;
                    state    <= S_ADDR;
                end
                S_ADDR, S_WDATA: begin
                    if (rx_stb) begin
                        idle_cnt <= '0;
                        if (state == S_ADDR) wb_addr  <= AW'({wb_addr, rx_data});
                        else                 wb_wdata <= DW'({wb_wdata, rx_data});
                        if (byte_cnt == last_cnt) begin
                            byte_cnt <= '0;
                            if (state == S_ADDR && is_wr) state <= S_WDATA;
                            else begin
                                state  <= S_BUS;
                                wb_cyc <= 1'b1;
                                wb_we  <= is_wr;
                                to_cnt <= '0;
                            end
                        end else byte_cnt <= byte_cnt + 1'b1;
                    end else if (&idle_cnt) state <= S_IDLE;
                    else idle_cnt <= idle_cnt + 1'b1;
                end
                S_BUS: if (bus_done) begin
                    wb_cyc   <= 1'b0;
                    wb_we    <= 1'b0;
                    rd_buf   <= bus_data;
                    status   <= bus_stat;
                    tx_valid <= 1'b1;
                    byte_cnt <= '0;
                    if (is_wr) begin
                        tx_data <= bus_stat;
                        state   <= S_RESP_STAT;
                    end else begin
                        tx_data <= bus_data[DW-1 -: 8];
                        state   <= S_RESP_DATA;
                    end
                end else to_cnt <= to_cnt + 1'b1;
                S_RESP_DATA: if (tx_ack) begin
                    rd_buf <= rd_next;
                    if (byte_cnt == CW'(DB - 1)) begin
                        tx_data <= status;
                        state   <= S_RESP_STAT;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                        tx_data  <= rd_next[DW-1 -: 8];
                    end
                end
                S_RESP_STAT: if (tx_ack) begin
                    tx_valid <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: serial host driver/monitor, registered-ack slave,
// and a frame-level model of expected bus cycles and response bytes.
module tb_uart_wb_master;
    localparam logic [7:0] DIV_TB = 8'd24;
    localparam int BIT    = 25;
    localparam int IDLE_W = 12;
    localparam int BYTE_T = 10 * BIT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic [15:0] wb_addr, wb_wdata, wb_rdata;
    logic        wb_we, wb_cyc;
    logic        wb_ack = 1'b0;

    logic [15:0] slv_rdata = '0;
    bit          slv_stall = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int we_err = 0;
    int hold_err = 0;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        int          len;
    } txn_t;

    txn_t       bus_q[$];
    logic [7:0] resp_q[$];

    uart_wb_master #(.DIV_WIDTH(8), .DIV(DIV_TB), .AW(16), .DW(16),
                     .TO_WIDTH(8), .IDLE_WIDTH(IDLE_W)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    assign wb_rdata = slv_rdata;

    always @(posedge clk) wb_ack <= wb_cyc && !wb_ack && !slv_stall;

    // Bus monitor: one record per wb_cyc pulse, length in clocks
    txn_t cur;
    bit   in_cyc = 1'b0;
    always @(negedge clk) begin
        if (!wb_cyc && wb_we) we_err++;
        if (wb_cyc) begin
            if (!in_cyc) begin
                cur.addr = wb_addr; cur.we = wb_we; cur.wdata = wb_wdata; cur.len = 1;
                in_cyc = 1'b1;
            end else begin
                if (wb_addr != cur.addr || wb_wdata != cur.wdata || wb_we != cur.we) hold_err++;
                cur.len++;
            end
        end else if (in_cyc) begin
            bus_q.push_back(cur);
            in_cyc = 1'b0;
        end
    end

    // Serial monitor on uart_tx
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (BIT) @(negedge clk);
            resp_q.push_back(b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (BIT) @(negedge clk);
        end
        repeat (BIT) @(negedge clk);
    endtask

    task automatic wait_resp(input int n);
        for (int i = 0; i < 8 * BYTE_T && resp_q.size() < n; i++) @(negedge clk);
        repeat (2 * BYTE_T) @(negedge clk);
    endtask

    // Model: a frame of kind/addr/wdata against a slave returning rdata (or stalling)
    task automatic do_frame(input string tag, input logic [1:0] kind, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] rdata, input bit stall);
        int          n_txn, n_resp;
        logic [15:0] rd_exp;
        logic [7:0]  st_exp;
        logic [7:0]  exp_resp[$];
        bus_q.delete();
        resp_q.delete();
        slv_rdata = rdata;
        slv_stall = stall;
        send_byte({kind, 6'($urandom_range(0, 63))});
        if (kind == 2'b01 || kind == 2'b10) begin
            send_byte(addr[15:8]);
            send_byte(addr[7:0]);
        end
        if (kind == 2'b01) begin
            send_byte(wdata[15:8]);
            send_byte(wdata[7:0]);
        end
        n_txn  = (kind == 2'b01 || kind == 2'b10) ? 1 : 0;
        rd_exp = stall ? 16'h0000 : rdata;
        st_exp = stall ? 8'hEE : 8'hA5;
        if (kind == 2'b10) begin
            exp_resp.push_back(rd_exp[15:8]);
            exp_resp.push_back(rd_exp[7:0]);
        end
        if (n_txn == 1) exp_resp.push_back(st_exp);
        n_resp = exp_resp.size();
        wait_resp(n_resp);
        chk({tag, ".ncyc"}, bus_q.size(), n_txn);
        if (bus_q.size() > 0 && n_txn == 1) begin
            chk({tag, ".addr"}, bus_q[0].addr, addr);
            chk({tag, ".we"}, bus_q[0].we, (kind == 2'b01));
            if (kind == 2'b01) chk({tag, ".wdata"}, bus_q[0].wdata, wdata);
            chk({tag, ".len"}, bus_q[0].len, stall ? 255 : 2);
        end
        chk({tag, ".nresp"}, resp_q.size(), n_resp);
        for (int i = 0; i < n_resp && i < resp_q.size(); i++)
            chk($sformatf("%s.resp%0d", tag, i), resp_q[i], exp_resp[i]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.cyc", wb_cyc, 0);
        chk("rst.we", wb_we, 0);
        chk("rst.addr", wb_addr, 0);
        chk("rst.wdata", wb_wdata, 0);
        chk("rst.tx", uart_tx, 1);
        rst = 1'b0;
        repeat (5 * BIT) @(negedge clk);

        do_frame("wr", 2'b01, 16'h1234, 16'hBEEF, 16'h0000, 1'b0);
        do_frame("rd", 2'b10, 16'h0004, 16'h0000, 16'hCAFE, 1'b0);
        do_frame("tmo", 2'b10, 16'h0008, 16'h0000, 16'h5555, 1'b1);
        do_frame("nop", 2'b00, 16'h0, 16'h0, 16'h0, 1'b0);
        do_frame("rsv", 2'b11, 16'h0, 16'h0, 16'h0, 1'b0);
        do_frame("rd2", 2'b10, 16'h0004, 16'h0000, 16'hCAFE, 1'b0);

        // Partial write frame left idle past the abort window, then a clean read
        send_byte(8'h40);
        send_byte(8'h12);
        repeat ((1 << IDLE_W) + 200) @(negedge clk);
        do_frame("abort", 2'b10, 16'h0004, 16'h0000, 16'hCAFE, 1'b0);

        for (int k = 0; k < 10; k++)
            do_frame($sformatf("rnd%0d", k), 2'($urandom_range(0, 3)), 16'($urandom),
                     16'($urandom), 16'($urandom), ($urandom_range(0, 4) == 0));

        chk("we_drop", we_err, 0);
        chk("hold", hold_err, 0);

        // Reset while a stalled read is on the bus
        slv_stall = 1'b1;
        send_byte(8'h80);
        send_byte(8'h00);
        send_byte(8'h08);
        for (int i = 0; i < 4 * BYTE_T && !wb_cyc; i++) @(negedge clk);
        chk("mid.cyc_up", wb_cyc, 1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid.cyc", wb_cyc, 0);
        chk("mid.tx", uart_tx, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_q.delete();
        resp_q.delete();
        repeat (4 * BYTE_T) @(negedge clk);
        chk("mid.nresp", resp_q.size(), 0);
        chk("mid.ncyc", bus_q.size(), 0);
        chk("mid.txidle", uart_tx, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
